// File: rtl/elevator_request_scheduler.sv
// rtl/elevator_request_scheduler.sv - call-button latching and SCAN target selection for elevator_top
module elevator_request_scheduler #(
    parameter int NUM_FLOORS   = 4,
    parameter int FLOOR_W      = 2,
    parameter int HOME_FLOOR   = 0,
    parameter int IDLE_TIMEOUT = 200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    curr_floor,
    input  logic                  door_open,
    input  logic                  motor_up,
    input  logic                  motor_down,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic                  req_valid,
    output logic                  homing,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SWEEP_UP   = 2'd1,
        ST_SWEEP_DOWN = 2'd2
    } state_t;

    localparam logic [FLOOR_W-1:0] HOME_L    = FLOOR_W'(HOME_FLOOR);
    localparam logic [15:0]        TIMEOUT_L = 16'(IDLE_TIMEOUT);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [NUM_FLOORS-1:0]   r_btn_q;
    logic [NUM_FLOORS-1:0]   r_pending;
    logic [FLOOR_W-1:0]      r_req_floor;
    logic                    r_req_valid;
    logic                    r_homing;
    logic                    r_dir_up;
    logic [15:0]             r_idle_cnt;

    logic [NUM_FLOORS-1:0]   w_edge;
    logic [NUM_FLOORS-1:0]   w_clr;
    logic [NUM_FLOORS-1:0]   w_pending_next;
    logic                    w_idle_car;
    logic                    w_any;
    logic                    w_cnt_cond;
    logic [15:0]             w_cnt_next;
    logic                    w_homing_next;
    logic [FLOOR_W-1:0]      w_req_floor_next;
    logic                    w_req_valid_next;
    logic                    w_dir_up_next;

    logic                    w_ge_found, w_gt_found, w_le_found, w_lt_found;
    logic [FLOOR_W-1:0]      w_ge, w_gt, w_le, w_lt;
    logic [FLOOR_W-1:0]      w_dist_up, w_dist_dn;

    // Button rising edges set requests; an open door clears its floor, and the clear wins.
    assign w_edge         = call_btn & ~r_btn_q;
    assign w_clr          = door_open ? ({{(NUM_FLOORS-1){1'b0}}, 1'b1} << curr_floor) : '0;
    assign w_pending_next = (r_pending | w_edge) & ~w_clr;

    assign w_idle_car = !(motor_up | motor_down) && !door_open;
    assign w_any      = |r_pending;

    // Idle counter saturates at the timeout; homing asserts the cycle the count arrives there.
    assign w_cnt_cond = (r_state == ST_IDLE) && !w_any && w_idle_car &&
                        (curr_floor != HOME_L) && (TIMEOUT_L != 16'd0);
    assign w_cnt_next = !w_cnt_cond ? 16'd0 :
                        (r_idle_cnt == TIMEOUT_L) ? r_idle_cnt : r_idle_cnt + 16'd1;

    // Homing is released by arrival at home or by any latched request.
    always_comb begin
        w_homing_next = r_homing;
        if ((curr_floor == HOME_L) || w_any) begin
            w_homing_next = 1'b0;
        end else if (w_cnt_cond && (w_cnt_next == TIMEOUT_L)) begin
            w_homing_next = 1'b1;
        end
    end

    // Nearest pending floors on each side of the car, inclusive and exclusive of the current floor.
    always_comb begin
        w_ge_found = 1'b0;
        w_gt_found = 1'b0;
        w_le_found = 1'b0;
        w_lt_found = 1'b0;
        w_ge       = '0;
        w_gt       = '0;
        w_le       = '0;
        w_lt       = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (r_pending[i] && (FLOOR_W'(i) >= curr_floor)) begin
                w_ge_found = 1'b1;
                w_ge       = FLOOR_W'(i);
            end
            if (r_pending[i] && (FLOOR_W'(i) > curr_floor)) begin
                w_gt_found = 1'b1;
                w_gt       = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (r_pending[i] && (FLOOR_W'(i) <= curr_floor)) begin
                w_le_found = 1'b1;
                w_le       = FLOOR_W'(i);
            end
            if (r_pending[i] && (FLOOR_W'(i) < curr_floor)) begin
                w_lt_found = 1'b1;
                w_lt       = FLOOR_W'(i);
            end
        end
    end

    assign w_dist_up = w_gt - curr_floor;
    assign w_dist_dn = curr_floor - w_lt;

    // SCAN next-state and target selection; everything holds unless the car is stopped with doors shut.
    always_comb begin
        w_state_next     = r_state;
        w_req_floor_next = r_req_floor;
        w_req_valid_next = r_req_valid;
        w_dir_up_next    = r_dir_up;
        if (w_idle_car) begin
            unique case (r_state)
                ST_SWEEP_UP: begin
                    if (w_ge_found) begin
                        w_req_floor_next = w_ge;
                        w_req_valid_next = 1'b1;
                    end else if (w_lt_found) begin
                        w_req_floor_next = w_lt;
                        w_req_valid_next = 1'b1;
                        w_state_next     = ST_SWEEP_DOWN;
                        w_dir_up_next    = 1'b0;
                    end else begin
                        w_req_floor_next = curr_floor;
                        w_req_valid_next = 1'b0;
                        w_state_next     = ST_IDLE;
                    end
                end
                ST_SWEEP_DOWN: begin
                    if (w_le_found) begin
                        w_req_floor_next = w_le;
                        w_req_valid_next = 1'b1;
                    end else if (w_gt_found) begin
                        w_req_floor_next = w_gt;
                        w_req_valid_next = 1'b1;
                        w_state_next     = ST_SWEEP_UP;
                        w_dir_up_next    = 1'b1;
                    end else begin
                        w_req_floor_next = curr_floor;
                        w_req_valid_next = 1'b0;
                        w_state_next     = ST_IDLE;
                    end
                end
                default: begin
                    if (!w_any) begin
                        w_req_floor_next = w_homing_next ? HOME_L : curr_floor;
                        w_req_valid_next = 1'b0;
                    end else if (r_pending[curr_floor]) begin
                        w_req_floor_next = curr_floor;
                        w_req_valid_next = 1'b1;
                    end else if (w_gt_found && (!w_lt_found || (w_dist_up <= w_dist_dn))) begin
                        w_req_floor_next = w_gt;
                        w_req_valid_next = 1'b1;
                        w_state_next     = ST_SWEEP_UP;
                        w_dir_up_next    = 1'b1;
                    end else begin
                        w_req_floor_next = w_lt;
                        w_req_valid_next = 1'b1;
                        w_state_next     = ST_SWEEP_DOWN;
                        w_dir_up_next    = 1'b0;
                    end
                end
            endcase
        end
    end

    // State, target and request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_btn_q     <= '0;
            r_pending   <= '0;
            r_req_floor <= HOME_L;
            r_req_valid <= 1'b0;
            r_homing    <= 1'b0;
            r_dir_up    <= 1'b1;
            r_idle_cnt  <= 16'd0;
        end else begin
            r_state     <= w_state_next;
            r_btn_q     <= call_btn;
            r_pending   <= w_pending_next;
            r_req_floor <= w_req_floor_next;
            r_req_valid <= w_req_valid_next;
            r_homing    <= w_homing_next;
            r_dir_up    <= w_dir_up_next;
            r_idle_cnt  <= w_cnt_next;
        end
    end

    assign req_floor = r_req_floor;
    assign req_valid = r_req_valid;
    assign homing    = r_homing;
    assign pending   = r_pending;
    assign dir_up    = r_dir_up;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// tb/tb_elevator_request_scheduler.sv - directed checks for elevator_request_scheduler
module tb_elevator_request_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] call_btn;
    logic [1:0] curr_floor;
    logic       door_open;
    logic       motor_up;
    logic       motor_down;
    logic [1:0] req_floor;
    logic       req_valid;
    logic       homing;
    logic [3:0] pending;
    logic       dir_up;

    int n_checks = 0;
    int n_pass   = 0;

    elevator_request_scheduler #(
        .NUM_FLOORS  (4),
        .FLOOR_W     (2),
        .HOME_FLOOR  (0),
        .IDLE_TIMEOUT(10)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .call_btn  (call_btn),
        .curr_floor(curr_floor),
        .door_open (door_open),
        .motor_up  (motor_up),
        .motor_down(motor_down),
        .req_floor (req_floor),
        .req_valid (req_valid),
        .homing    (homing),
        .pending   (pending),
        .dir_up    (dir_up)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] floor);
        reset      = 1'b0;
        call_btn   = 4'b0000;
        curr_floor = floor;
        door_open  = 1'b0;
        motor_up   = 1'b0;
        motor_down = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    initial begin
        // reset state
        do_reset(2'd0);
        check_eq("rst_pending", pending, 0);
        check_eq("rst_req_floor", req_floor, 0);
        check_eq("rst_req_valid", req_valid, 0);
        check_eq("rst_dir_up", dir_up, 1);
        check_eq("rst_homing", homing, 0);

        // single request to floor 2 and its service
        call_btn = 4'b0100; tick(); call_btn = 4'b0000;
        check_eq("t2_pending_set", pending, 4);
        check_eq("t2_valid_lag", req_valid, 0);
        tick();
        check_eq("t2_req_floor", req_floor, 2);
        check_eq("t2_req_valid", req_valid, 1);
        check_eq("t2_dir_up", dir_up, 1);
        motor_up = 1'b1; tick();
        curr_floor = 2'd1; tick();
        check_eq("t2_hold_moving", req_floor, 2);
        curr_floor = 2'd2; motor_up = 1'b0; door_open = 1'b1; tick();
        check_eq("t2_cleared", pending, 0);
        check_eq("t2_valid_held_door", req_valid, 1);
        door_open = 1'b0; tick();
        check_eq("t2_valid_drop", req_valid, 0);
        check_eq("t2_floor_after", req_floor, 2);

        // sweep up to top then reverse
        do_reset(2'd0);
        call_btn = 4'b1000; tick(); call_btn = 4'b0000; tick();
        check_eq("t3_req3", req_floor, 3);
        motor_up = 1'b1; tick();
        curr_floor = 2'd1; call_btn = 4'b0001; tick();
        call_btn = 4'b0000; motor_up = 1'b0; tick();
        check_eq("t3_pending", pending, 9);
        check_eq("t3_keep_up", req_floor, 3);
        check_eq("t3_dir_up", dir_up, 1);
        curr_floor = 2'd3; door_open = 1'b1; tick();
        check_eq("t3_served3", pending, 1);
        door_open = 1'b0; tick();
        check_eq("t3_rev_floor", req_floor, 0);
        check_eq("t3_rev_dir", dir_up, 0);
        check_eq("t3_rev_valid", req_valid, 1);

        // distance tie breaks upward
        do_reset(2'd1);
        call_btn = 4'b0101; tick(); call_btn = 4'b0000; tick();
        check_eq("t4_tie_floor", req_floor, 2);
        check_eq("t4_tie_dir", dir_up, 1);
        curr_floor = 2'd2; door_open = 1'b1; tick();
        door_open = 1'b0; tick();
        check_eq("t4_then_floor0", req_floor, 0);
        check_eq("t4_then_dir", dir_up, 0);

        // target held while moving, clear wins at open door, held button does not re-latch
        do_reset(2'd0);
        call_btn = 4'b0100; tick(); call_btn = 4'b0000; tick();
        motor_up = 1'b1; tick();
        call_btn = 4'b1000; tick(); call_btn = 4'b0000; tick();
        check_eq("t5_hold_target", req_floor, 2);
        check_eq("t5_pending", pending, 12);
        curr_floor = 2'd2; motor_up = 1'b0; door_open = 1'b1; tick();
        call_btn = 4'b0100; tick();
        check_eq("t5_clear_wins", pending, 8);
        check_eq("t5_door_hold", req_floor, 2);
        door_open = 1'b0; tick();
        check_eq("t5_no_relatch", pending, 8);
        check_eq("t5_next_up", req_floor, 3);
        call_btn = 4'b0000;

        // all four at once, then reset mid-travel with buttons held through release
        do_reset(2'd0);
        call_btn = 4'b1111; tick();
        check_eq("t6_all_set", pending, 15);
        tick();
        check_eq("t6_here_floor", req_floor, 0);
        check_eq("t6_here_valid", req_valid, 1);
        motor_up = 1'b1; reset = 1'b0; tick();
        check_eq("t6_rst_pending", pending, 0);
        check_eq("t6_rst_valid", req_valid, 0);
        check_eq("t6_rst_dir", dir_up, 1);
        reset = 1'b1; tick();
        check_eq("t6_held_edge", pending, 15);
        call_btn = 4'b0000;

        // idle timeout homing and override by a new request
        do_reset(2'd3);
        repeat (9) tick();
        check_eq("t7_pre_homing", homing, 0);
        check_eq("t7_pre_floor", req_floor, 3);
        tick();
        check_eq("t7_homing", homing, 1);
        check_eq("t7_home_floor", req_floor, 0);
        check_eq("t7_home_valid", req_valid, 0);
        tick();
        call_btn = 4'b0010; tick(); call_btn = 4'b0000;
        check_eq("t7_homing_lag", homing, 1);
        tick();
        check_eq("t7_homing_drop", homing, 0);
        check_eq("t7_new_floor", req_floor, 1);
        check_eq("t7_new_valid", req_valid, 1);
        check_eq("t7_new_dir", dir_up, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
- Upstream stage of elevator_top. Latches per-floor call-button presses into a pending-request register and selects the next target floor with a collective (SCAN) policy.
- Drives the controller's req_floor input and observes its curr_floor, door_open, motor_up and motor_down outputs to decide when a request has been served.
- Returns the car to a home floor after a programmable idle interval.

Parameters:
- NUM_FLOORS, 4, number of floors; fixed at 4 in this revision.
- FLOOR_W, 2, width of floor indices.
- HOME_FLOOR, 0, floor the car returns to when idle.
- IDLE_TIMEOUT, 200, clk cycles of full idleness before homing; 0 disables homing.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- call_btn  input  NUM_FLOORS  raw call buttons, bit i = floor i, level (held or pulsed).
- curr_floor  input  FLOOR_W  current floor from elevator_top.
- door_open  input  1  door status from elevator_top.
- motor_up  input  1  car moving up.
- motor_down  input  1  car moving down.
- req_floor  output  FLOOR_W  target floor to elevator_top, registered.
- req_valid  output  1  req_floor holds a real pending request.
- homing  output  1  req_floor is HOME_FLOOR due to idle timeout.
- pending  output  NUM_FLOORS  latched requests, for the hall lamps.
- dir_up  output  1  current sweep direction, 1 = up.

Behaviour:
- All state is clocked on the rising edge of clk. Reset is sampled only on a clk edge, with reset==0 meaning reset.
- Reset values:
  - pending=0, req_floor=HOME_FLOOR, req_valid=0, homing=0, dir_up=1.
  - state=IDLE, idle counter=0, button edge-history register=0.
- Button capture:
  - Rising-edge detect per bit against a registered copy of call_btn.
  - An edge sampled at cycle N sets pending[i] at N+1.
  - Holding a button does not re-set the bit after it has been cleared. A new edge is required.
  - A button held through reset release counts as one edge on the first cycle out of reset.
- Service clear:
  - pending[curr_floor] clears on any cycle where door_open==1.
  - If a set and a clear hit the same bit in the same cycle, the clear wins.
- Movement gating:
  - "moving" = motor_up | motor_down. "idle_car" = !moving & !door_open.
  - req_floor, req_valid and the state are re-evaluated only on idle_car cycles. Otherwise they hold.
  - The target therefore never changes mid-travel or while the door is open.
  - Decision latency: pending change at N -> req_floor/req_valid update at N+1 if idle_car.
- States: IDLE, SWEEP_UP, SWEEP_DOWN. Evaluated on idle_car cycles, with c = curr_floor.
  - IDLE, no pending: req_valid=0, req_floor=c unless homing.
  - IDLE, pending[c]: target c, stay IDLE, req_valid=1.
  - IDLE, otherwise: target the nearest pending floor. On a distance tie, the floor above wins. Next state is SWEEP_UP if the target > c, else SWEEP_DOWN. dir_up follows.
  - SWEEP_UP: target the lowest pending floor >= c.
    - If none, target the highest pending floor < c, go to SWEEP_DOWN and set dir_up=0.
    - If no pending at all, go to IDLE with req_valid=0.
  - SWEEP_DOWN: mirror of SWEEP_UP. Target the highest pending floor <= c, else reverse to SWEEP_UP, else go to IDLE.
  - req_valid=1 whenever a pending floor is targeted.
- Homing:
  - The idle counter increments while state==IDLE, pending==0, idle_car, c!=HOME_FLOOR and IDLE_TIMEOUT!=0.
  - Any other cycle clears the counter.
  - When the count reaches IDLE_TIMEOUT: req_floor=HOME_FLOOR, homing=1, req_valid=0.
  - homing drops when c==HOME_FLOOR or any pending bit sets. A new request overrides the home target on the next idle_car cycle.
  - The counter saturates and does not wrap.
- Boundaries:
  - c at the top floor in SWEEP_UP with no request there reverses direction.
  - c at floor 0 in SWEEP_DOWN reverses direction likewise.
  - All four buttons pressed in one cycle: all four pending bits set at N+1.
  - Reset mid-travel: all state returns to reset values on the next edge and pending requests are lost.

Test Plan:
- Reset for 2 cycles, then release with call_btn=0 -> pending=0, req_floor=0, req_valid=0, dir_up=1, homing=0.
- curr_floor=0, idle car, pulse call_btn=4'b0100 for 1 cycle -> pending=4'b0100 next cycle, then req_floor=2, req_valid=1, dir_up=1. Drive motor_up, then curr_floor=2 and door_open=1 -> pending=0 and req_valid=0 once the car is idle again.
- curr_floor=1 in SWEEP_UP, pending=4'b1001 -> req_floor=3. After floor 3 is served -> SWEEP_DOWN, req_floor=0, dir_up=0.
- curr_floor=1 in IDLE, press floors 0 and 2 in the same cycle -> tie resolved upward: req_floor=2, then req_floor=0 after floor 2 is served.
- Press floor 3 while motor_up=1 with target 2 -> req_floor stays 2 until idle_car. Press floor 2 while door_open at floor 2 -> pending[2] stays 0.
- IDLE_TIMEOUT=10, curr_floor=3, no requests for 10 idle cycles -> req_floor=0, homing=1. A button press at cycle 12 -> homing=0 and req_floor = the pressed floor on the next idle_car cycle.
